// File: rtl/demux4_stream.sv
// demux4_stream: one valid/ready input fanned out to four independent output
// lanes, each backed by a 2-entry FIFO so a stalled consumer only blocks
// traffic addressed to its own lane.
// Optional feature: define DEMUX_RR_EN to add the rr_mode input and a 2-bit
// round-robin destination pointer. The default build routes by s_sel only.
module demux4_stream #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  input  logic [1:0]         s_sel,
  output logic [3:0]         m_valid,
  input  logic [3:0]         m_ready,
  output logic [4*WIDTH-1:0] m_data,
  output logic [3:0]         lane_full
`ifdef DEMUX_RR_EN
  ,
  input  logic               rr_mode
`endif
);

  // Per-lane FIFO state: fill count 0..2, 1-bit write/read pointers, 2 slots.
  logic [1:0]       count_r  [4];
  logic             wr_ptr_r [4];
  logic             rd_ptr_r [4];
  logic [WIDTH-1:0] mem_r    [4][2];

  // Routing and handshake decode.
  logic [1:0] dest_s;
  logic       accept_s;
  logic [3:0] push_s;
  logic [3:0] pop_s;

`ifdef DEMUX_RR_EN
  logic [1:0] rr_ptr_r;

  // Destination comes from the round-robin pointer in rr mode, else from s_sel.
  always_comb begin
    if (rr_mode) begin
      dest_s = rr_ptr_r;
    end else begin
      dest_s = s_sel;
    end
  end

  // Pointer moves on accepted words in rr mode only; a full lane is never skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= 2'd0;
    end else if (accept_s && rr_mode) begin
      rr_ptr_r <= rr_ptr_r + 2'd1;
    end
  end
`else
  // Destination is always the sampled select.
  always_comb begin
    dest_s = s_sel;
  end
`endif

  // Lane status and head words decode straight from registered FIFO state.
  always_comb begin
    m_valid   = 4'b0000;
    lane_full = 4'b0000;
    m_data    = {(4*WIDTH){1'b0}};
    for (int i = 0; i < 4; i++) begin
      m_valid[i]               = (count_r[i] != 2'd0);
      lane_full[i]             = (count_r[i] == 2'd2);
      m_data[i*WIDTH +: WIDTH] = mem_r[i][rd_ptr_r[i]];
    end
  end

  // Input readiness depends only on the destination lane's registered fill
  // level; a full lane refuses a push even if it is popping this cycle.
  always_comb begin
    s_ready  = ~lane_full[dest_s];
    accept_s = s_valid & s_ready;
  end

  // One-hot push to the destination lane, independent pops per lane.
  always_comb begin
    push_s = 4'b0000;
    pop_s  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      push_s[i] = accept_s && (dest_s == 2'(i));
      pop_s[i]  = m_valid[i] && m_ready[i];
    end
  end

  // FIFO storage, pointers and counts; reset clears storage so m_data is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        count_r[i]  <= 2'd0;
        wr_ptr_r[i] <= 1'b0;
        rd_ptr_r[i] <= 1'b0;
        mem_r[i][0] <= {WIDTH{1'b0}};
        mem_r[i][1] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_s[i]) begin
          mem_r[i][wr_ptr_r[i]] <= s_data;
          wr_ptr_r[i]           <= ~wr_ptr_r[i];
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= ~rd_ptr_r[i];
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + 2'd1;
          2'b01:   count_r[i] <= count_r[i] - 2'd1;
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed scenarios plus a randomized phase. A reference
// model keeps one queue of expected words per lane; each cycle it checks the
// DUT's status outputs and head words against those queues.
module tb_demux4_stream;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic [1:0]     s_sel;
  logic [3:0]     m_valid;
  logic [3:0]     m_ready;
  logic [4*W-1:0] m_data;
  logic [3:0]     lane_full;
  logic           rr_mode_tb;

  int checks;
  int failures;

  typedef logic [W-1:0] word_q_t [$];
  word_q_t exp_q [4];
  int      rr_ptr_m;
  logic    last_ready;

  // Model scratch variables.
  logic [1:0] md;
  logic [3:0] mev;
  logic [3:0] mef;
  logic [W-1:0] mexp;

  demux4_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sel     (s_sel),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .lane_full (lane_full)
`ifdef DEMUX_RR_EN
    ,
    .rr_mode   (rr_mode_tb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: checks outputs mid-cycle, then applies this cycle's pops and push.
  always @(negedge clk) begin
    if (!rst) begin
      md = rr_mode_tb ? 2'(rr_ptr_m) : s_sel;
      for (int i = 0; i < 4; i++) begin
        mev[i] = (exp_q[i].size() != 0);
        mef[i] = (exp_q[i].size() == 2);
      end
      chk("m_valid", {28'd0, m_valid}, {28'd0, mev});
      chk("lane_full", {28'd0, lane_full}, {28'd0, mef});
      chk("s_ready", {31'd0, s_ready}, {31'd0, ~mef[md]});
      for (int i = 0; i < 4; i++) begin
        if (mev[i]) begin
          mexp = exp_q[i][0];
          chk($sformatf("lane%0d_data", i), {24'd0, m_data[i*W +: W]}, {24'd0, mexp});
          if (m_ready[i]) begin
            void'(exp_q[i].pop_front());
          end
        end
      end
      if (s_valid && !mef[md]) begin
        exp_q[md].push_back(s_data);
        if (rr_mode_tb) begin
          rr_ptr_m = (rr_ptr_m + 1) % 4;
        end
      end
      last_ready = s_ready;
    end
  end

  task automatic cyc(input logic v, input logic [1:0] sel, input logic [W-1:0] d, input logic [3:0] rdy);
    @(posedge clk);
    #1;
    s_valid = v;
    s_sel   = sel;
    s_data  = d;
    m_ready = rdy;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
    end
    rr_ptr_m = 0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_sel      = 2'd0;
    s_data     = 8'd0;
    m_ready    = 4'd0;
    rr_mode_tb = 1'b0;
    last_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    mid();
    chk("rst_m_valid", {28'd0, m_valid}, 32'd0);
    chk("rst_lane_full", {28'd0, lane_full}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_data", m_data, 32'd0);

    // One word per lane, all consumers ready.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 2'(k), 8'(k + 1), 4'hF);
    end
    cyc(1'b0, 2'd0, 8'd0, 4'hF);
    mid();
    chk("t1_lane_d_valid", {28'd0, m_valid}, 32'h8);
    chk("t1_lane_d_data", {24'd0, m_data[3*W +: W]}, 32'h4);
    cyc(1'b0, 2'd0, 8'd0, 4'hF);

    // Lane b stalled: two words fit, third waits until a slot frees.
    cyc(1'b1, 2'd1, 8'h0A, 4'b1101);
    cyc(1'b1, 2'd1, 8'h0B, 4'b1101);
    cyc(1'b1, 2'd1, 8'h0C, 4'b1101);
    mid();
    chk("t2_full_b", {28'd0, lane_full}, 32'h2);
    chk("t2_refuse", {31'd0, s_ready}, 32'd0);
    cyc(1'b1, 2'd1, 8'h0C, 4'b1101);
    mid();
    chk("t2_still_refuse", {31'd0, s_ready}, 32'd0);
    cyc(1'b1, 2'd1, 8'h0C, 4'b1111);
    mid();
    chk("t2_full_pop_refuse", {31'd0, s_ready}, 32'd0);
    chk("t2_head_a", {24'd0, m_data[W +: W]}, 32'h0A);
    cyc(1'b1, 2'd1, 8'h0C, 4'b1111);
    mid();
    chk("t2_accept_third", {31'd0, s_ready}, 32'd1);
    chk("t2_head_b", {24'd0, m_data[W +: W]}, 32'h0B);
    repeat (3) cyc(1'b0, 2'd0, 8'd0, 4'hF);

    // Lane b full does not block lane c.
    cyc(1'b1, 2'd1, 8'h11, 4'b1101);
    cyc(1'b1, 2'd1, 8'h12, 4'b1101);
    cyc(1'b1, 2'd2, 8'h05, 4'b1101);
    mid();
    chk("t3_c_ready", {31'd0, s_ready}, 32'd1);
    cyc(1'b0, 2'd0, 8'd0, 4'b1101);
    mid();
    chk("t3_c_data", {24'd0, m_data[2*W +: W]}, 32'h05);
    chk("t3_valid", {28'd0, m_valid}, 32'h6);
    repeat (3) cyc(1'b0, 2'd0, 8'd0, 4'hF);

    // Lane a count 1 with simultaneous push and pop.
    cyc(1'b1, 2'd0, 8'h06, 4'b1110);
    cyc(1'b1, 2'd0, 8'h07, 4'b1111);
    mid();
    chk("t4_head_old", {24'd0, m_data[W-1:0]}, 32'h06);
    cyc(1'b0, 2'd0, 8'd0, 4'b1110);
    mid();
    chk("t4_head_new", {24'd0, m_data[W-1:0]}, 32'h07);
    chk("t4_not_full", {28'd0, lane_full}, 32'h0);
    repeat (2) cyc(1'b0, 2'd0, 8'd0, 4'hF);

    // Reset mid-operation with lanes a and d full.
    cyc(1'b1, 2'd0, 8'h21, 4'h0);
    cyc(1'b1, 2'd0, 8'h22, 4'h0);
    cyc(1'b1, 2'd3, 8'h31, 4'h0);
    cyc(1'b1, 2'd3, 8'h32, 4'h0);
    cyc(1'b0, 2'd0, 8'd0, 4'h0);
    mid();
    chk("t5_pre_full", {28'd0, lane_full}, 32'h9);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_clear();
    #1;
    chk("t5_m_valid", {28'd0, m_valid}, 32'd0);
    chk("t5_lane_full", {28'd0, lane_full}, 32'd0);
    chk("t5_s_ready", {31'd0, s_ready}, 32'd1);
    chk("t5_m_data", m_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cyc(1'b0, 2'd0, 8'd0, 4'hF);

`ifdef DEMUX_RR_EN
    // Round-robin routing with s_sel held at 0.
    rr_mode_tb = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 2'd0, 8'(k), 4'hF);
    end
    cyc(1'b0, 2'd0, 8'd0, 4'hF);
    mid();
    chk("t6_fifth_to_a", {28'd0, m_valid}, 32'h1);
    chk("t6_fifth_data", {24'd0, m_data[W-1:0]}, 32'h05);
    // Pointer now at b; stall lane c and fill it, then wrap to c again.
    for (int k = 0; k < 9; k++) begin
      cyc(1'b1, 2'd0, 8'(8'h40 + k), 4'b1011);
    end
    cyc(1'b1, 2'd0, 8'h50, 4'b1011);
    mid();
    chk("t6_c_full_refuse", {31'd0, s_ready}, 32'd0);
    cyc(1'b1, 2'd0, 8'h50, 4'b1111);
    mid();
    chk("t6_c_full_pop_refuse", {31'd0, s_ready}, 32'd0);
    cyc(1'b1, 2'd0, 8'h50, 4'b1111);
    mid();
    chk("t6_c_accept", {31'd0, s_ready}, 32'd1);
    repeat (4) cyc(1'b0, 2'd0, 8'd0, 4'hF);
    rr_mode_tb = 1'b0;
`endif

    // Randomized traffic honouring the producer hold rule.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      if (!(s_valid && !last_ready)) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_sel   = 2'($urandom_range(0, 3));
        s_data  = 8'($urandom);
`ifdef DEMUX_RR_EN
        rr_mode_tb = ($urandom_range(0, 2) == 0);
`endif
      end
      m_ready = 4'($urandom);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 4'hF;
    repeat (4) cyc(1'b0, 2'd0, 8'd0, 4'hF);
    mid();
    chk("drain_empty", {28'd0, m_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
